// File: rtl/psg_bus_arb_rr.sv
// N-channel PSG wave-table bus arbiter: round-robin or fixed priority, per-owner lock, grant-valid.
// Optional ack watchdog compiled in with `define PSG_ARB_WATCHDOG_EN.
module psg_bus_arb_rr #(
  parameter int NCH     = 8,
  parameter int RR      = 1,
  parameter int TIMEOUT = 255,
  localparam int SELW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic            ack,
  input  logic [NCH-1:0]  req,
  input  logic [NCH-1:0]  lock,
  output logic [NCH-1:0]  sel,
  output logic [SELW-1:0] seln,
  output logic            gnt_vld,
  output logic            timeout
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t          state_q, state_d;
  logic [NCH-1:0]  sel_q, sel_d;
  logic [SELW-1:0] seln_q, seln_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic            timeout_q, timeout_d;
  logic            wd_fire;
  logic [SELW:0]   pick_all, pick_excl;
  logic            do_load;
  logic [SELW-1:0] load_w;

  // Returns {found, index}; round-robin scans from the slot after p, fixed scans from 0.
  function automatic logic [SELW:0] pick(input logic [NCH-1:0] r, input logic [SELW-1:0] p);
    logic            found;
    logic [SELW-1:0] w;
    logic [SELW-1:0] jw;
    int              j;
    found = 1'b0;
    w     = '0;
    for (int k = 1; k <= NCH; k++) begin
      if (RR != 0) j = (int'(p) + k) % NCH;
      else         j = k - 1;
      jw = j[SELW-1:0];
      if (!found && r[jw]) begin
        found = 1'b1;
        w     = jw;
      end
    end
    return {found, w};
  endfunction

`ifdef PSG_ARB_WATCHDOG_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0] wd_q, wd_d;

  assign wd_fire = ce && (state_q == OWNED) && !ack && (wd_q == CW'(TIMEOUT - 1));

  always_comb begin
    wd_d = wd_q;
    if (state_q != OWNED)        wd_d = '0;
    else if (ce && (ack || wd_fire)) wd_d = '0;
    else if (ce)                 wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`else
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    pick_all  = pick(req, ptr_q);
    pick_excl = pick(req & ~sel_q, ptr_q);
    state_d   = state_q;
    timeout_d = wd_fire;
    do_load   = 1'b0;
    load_w    = '0;
    if (ce) begin
      unique case (state_q)
        IDLE: begin
          if (pick_all[SELW]) begin
            do_load = 1'b1;
            load_w  = pick_all[SELW-1:0];
          end
        end
        OWNED: begin
          if (ack) begin
            if (!(lock[seln_q] && req[seln_q])) begin
              if (pick_all[SELW]) begin
                do_load = 1'b1;
                load_w  = pick_all[SELW-1:0];
              end else begin
                state_d = IDLE;
              end
            end
          end else if (wd_fire) begin
            // Watchdog: lock is ignored and the stalled owner cannot win again.
            if (pick_excl[SELW]) begin
              do_load = 1'b1;
              load_w  = pick_excl[SELW-1:0];
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    sel_d  = sel_q;
    seln_d = seln_q;
    ptr_d  = ptr_q;
    if (do_load) begin
      state_d = OWNED;
      sel_d   = NCH'(1) << load_w;
      seln_d  = load_w;
      ptr_d   = load_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      seln_q    <= '0;
      ptr_q     <= SELW'(NCH - 1);
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      seln_q    <= seln_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end

  assign sel     = sel_q;
  assign seln    = seln_q;
  assign gnt_vld = (state_q == OWNED);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_psg_bus_arb_rr.sv
// Directed bench for psg_bus_arb_rr: per-cycle compare of the 8-channel RR instance against
// a behavioural model, plus literal checks on RR=0, NCH=5 and NCH=2 instances.
module tb_psg_bus_arb_rr;

  logic       clk, rst, ce, ack;
  logic [7:0] req, lock, sel, sel0;
  logic [2:0] seln, seln0;
  logic       vld, vld0, to, to0;

  logic       ack5;
  logic [4:0] req5, lock5, sel5;
  logic [2:0] seln5;
  logic       vld5, to5;

  logic       ack2;
  logic [1:0] req2, lock2, sel2;
  logic       seln2, vld2, to2;

  int n_vec = 0;
  int n_err = 0;

  psg_bus_arb_rr #(.NCH(8), .RR(1), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ce(ce), .ack(ack), .req(req), .lock(lock),
    .sel(sel), .seln(seln), .gnt_vld(vld), .timeout(to));

  psg_bus_arb_rr #(.NCH(8), .RR(0)) u_fix (
    .clk(clk), .rst(rst), .ce(ce), .ack(ack), .req(req), .lock(lock),
    .sel(sel0), .seln(seln0), .gnt_vld(vld0), .timeout(to0));

  psg_bus_arb_rr #(.NCH(5), .RR(1)) u_n5 (
    .clk(clk), .rst(rst), .ce(ce), .ack(ack5), .req(req5), .lock(lock5),
    .sel(sel5), .seln(seln5), .gnt_vld(vld5), .timeout(to5));

  psg_bus_arb_rr #(.NCH(2), .RR(1)) u_n2 (
    .clk(clk), .rst(rst), .ce(ce), .ack(ack2), .req(req2), .lock(lock2),
    .sel(sel2), .seln(seln2), .gnt_vld(vld2), .timeout(to2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model of the main instance (8 channels, round-robin, TIMEOUT=4).
  int  m_owner, m_ptr, m_cnt;
  bit  m_vld, m_started, m_to, m_ready;

  function automatic int rr_choose(input bit [7:0] r, input int after);
    for (int k = 1; k <= 8; k++) begin
      if (r[(after + k) % 8]) return (after + k) % 8;
    end
    return -1;
  endfunction

  task automatic m_grant(input int w);
    m_owner   = w;
    m_ptr     = w;
    m_vld     = 1'b1;
    m_started = 1'b1;
  endtask

  always @(posedge clk) begin
    bit [7:0] others;
    m_to = 1'b0;
    if (rst) begin
      m_owner = 0; m_ptr = 7; m_cnt = 0;
      m_vld = 1'b0; m_started = 1'b0; m_ready = 1'b1;
    end else if (ce) begin
      if (!m_vld) begin
        if (req != 8'h00) m_grant(rr_choose(req, m_ptr));
      end else if (ack) begin
        m_cnt = 0;
        if (lock[m_owner] && req[m_owner]) begin
          // owner keeps the bus
        end else if (req != 8'h00) begin
          m_grant(rr_choose(req, m_ptr));
        end else begin
          m_vld = 1'b0;
        end
      end else begin
`ifdef PSG_ARB_WATCHDOG_EN
        m_cnt++;
        if (m_cnt == 4) begin
          m_cnt  = 0;
          m_to   = 1'b1;
          others = req & ~(8'd1 << m_owner);
          if (others != 8'h00) m_grant(rr_choose(others, m_ptr));
          else                 m_vld = 1'b0;
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] e_sel;
    if (m_ready) begin
      e_sel = m_started ? (8'd1 << m_owner) : 8'd0;
      n_vec++;
      if (sel !== e_sel || seln !== 3'(m_owner) || vld !== m_vld || to !== m_to) begin
        n_err++;
        $display("FAIL cycle_cmp t=%0t sel=%h/%h seln=%0d/%0d gnt_vld=%b/%b timeout=%b/%b (got/exp)",
                 $time, sel, e_sel, seln, m_owner, vld, m_vld, to, m_to);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input bit c, input bit a, input bit [7:0] r, input bit [7:0] l);
    ce = c; ack = a; req = r; lock = l;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; ack = 1'b0; req = 8'h00; lock = 8'h00;
    ack5 = 1'b0; req5 = '0; lock5 = '0;
    ack2 = 1'b0; req2 = '0; lock2 = '0;

    // 1: reset dominates ce/ack/req; first grant
    cyc(1, 1, 8'hFF, 8'h00);
    cyc(1, 1, 8'hFF, 8'h00);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_seln", 32'(seln), 32'h0);
    chk("rst_vld", 32'(vld), 32'h0);
    chk("rst_to", 32'(to), 32'h0);
    rst = 1'b0;
    cyc(1, 0, 8'h81, 8'h00);
    chk("first_sel", 32'(sel), 32'h01);
    chk("first_vld", 32'(vld), 32'h1);
    chk("fix_first_seln", 32'(seln0), 32'h0);

    // 2: round-robin rotation vs fixed priority
    for (int k = 0; k < 8; k++) begin
      cyc(1, 1, 8'hFF, 8'h00);
      chk($sformatf("rr_seln_%0d", k), 32'(seln), 32'((k + 1) % 8));
      chk($sformatf("fix_seln_%0d", k), 32'(seln0), 32'h0);
    end

    // 3: lock retains owner, released lock re-arbitrates
    cyc(1, 1, 8'h08, 8'h00);
    chk("own3", 32'(seln), 32'h3);
    cyc(1, 1, 8'h28, 8'h08);
    chk("lock_hold", 32'(seln), 32'h3);
    cyc(1, 1, 8'h28, 8'h00);
    chk("unlock_seln", 32'(seln), 32'h5);
    chk("unlock_sel", 32'(sel), 32'h20);

    // 4: ack without ce ignored; release to idle holds last owner
    cyc(1, 1, 8'h04, 8'h00);
    for (int k = 0; k < 4; k++) cyc(0, 1, 8'hFF, 8'h00);
    chk("noce_seln", 32'(seln), 32'h2);
    cyc(1, 1, 8'h00, 8'h00);
    chk("idle_vld", 32'(vld), 32'h0);
    chk("idle_sel", 32'(sel), 32'h04);
    chk("idle_seln", 32'(seln), 32'h2);
    cyc(0, 0, 8'hFF, 8'h00);
    chk("idle_noce_vld", 32'(vld), 32'h0);
    cyc(1, 1, 8'h00, 8'h00);
    chk("idle_ack_vld", 32'(vld), 32'h0);

    // req drop while owned does not revoke; lock on non-owner ignored
    cyc(1, 0, 8'h10, 8'h00);
    cyc(1, 0, 8'h00, 8'h00);
    chk("reqdrop_seln", 32'(seln), 32'h4);
    chk("reqdrop_vld", 32'(vld), 32'h1);
    cyc(1, 1, 8'h20, 8'h00);
    cyc(1, 1, 8'h30, 8'h10);
    chk("nonowner_lock", 32'(seln), 32'h4);
    cyc(1, 1, 8'h00, 8'h00);

    // 5: NCH=5 wrap, NCH=2 alternation
    req5 = 5'b10000;
    cyc(1, 0, 8'h00, 8'h00);
    chk("n5_own4", 32'(seln5), 32'h4);
    req5 = 5'b00011; ack5 = 1'b1;
    cyc(1, 0, 8'h00, 8'h00);
    chk("n5_wrap_seln", 32'(seln5), 32'h0);
    chk("n5_wrap_sel", 32'(sel5), 32'h01);
    req5 = '0; ack5 = 1'b0;
    req2 = 2'b11;
    cyc(1, 0, 8'h00, 8'h00);
    chk("n2_first", 32'(seln2), 32'h0);
    ack2 = 1'b1;
    cyc(1, 0, 8'h00, 8'h00);
    chk("n2_second", 32'(seln2), 32'h1);
    chk("n2_sel", 32'(sel2), 32'h2);
    cyc(1, 0, 8'h00, 8'h00);
    chk("n2_third", 32'(seln2), 32'h0);
    req2 = '0; ack2 = 1'b0;

    // 6: stalled owner (watchdog fires on 4th tick when compiled in)
    cyc(1, 0, 8'h02, 8'h00);
    chk("wd_own1", 32'(seln), 32'h1);
    for (int k = 0; k < 3; k++) cyc(1, 0, 8'h06, 8'h00);
    chk("wd_pre_to", 32'(to), 32'h0);
    chk("wd_pre_seln", 32'(seln), 32'h1);
    cyc(1, 0, 8'h06, 8'h00);
`ifdef PSG_ARB_WATCHDOG_EN
    chk("wd_fire_to", 32'(to), 32'h1);
    chk("wd_fire_seln", 32'(seln), 32'h2);
`else
    chk("nowd_to", 32'(to), 32'h0);
    chk("nowd_seln", 32'(seln), 32'h1);
`endif
    cyc(0, 0, 8'h06, 8'h00);
    chk("wd_pulse_end", 32'(to), 32'h0);
    cyc(1, 1, 8'h02, 8'h00);
    chk("wd_own1b", 32'(seln), 32'h1);
    for (int k = 0; k < 4; k++) cyc(1, 0, 8'h02, 8'h00);
`ifdef PSG_ARB_WATCHDOG_EN
    chk("wd_idle_vld", 32'(vld), 32'h0);
    chk("wd_idle_to", 32'(to), 32'h1);
`else
    chk("nowd_hold_vld", 32'(vld), 32'h1);
    chk("nowd_hold_to", 32'(to), 32'h0);
`endif
    cyc(0, 0, 8'h00, 8'h00);
    cyc(0, 0, 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/psg_bus_arb_rr.md
Name: psg_bus_arb_rr

Overview:
Parametrised N-channel bus arbiter for PSG wave-table channels. It is the next generation of the fixed 8-way PSG arbiter and adds several features: configurable channel count, round-robin or fixed priority, per-channel bus lock, and an explicit grant-valid/idle state. It sits between the wave-table channel DMA requesters and the next level of the arbitration tree, and presents a single owner to the system bus.

Parameters:
NCH, 8, number of requesting channels (2..32).
RR, 1, 1 = round-robin starting after last owner; 0 = fixed priority, lowest index wins.
TIMEOUT, 255, ce-ticks an owner may hold the bus without ack before the watchdog fires (only used with PSG_ARB_WATCHDOG_EN); counter width = clog2(TIMEOUT+1).

Ports:
clk  in  1  system clock (eg 100MHz)
rst  in  1  reset, synchronous, active-high
ce  in  1  clock enable (eg 25MHz); all state changes except reset qualified by ce
ack  in  1  bus transfer completed by current owner
req  in  NCH  req[i] = channel i wants the bus
lock  in  NCH  lock[i] = channel i requests to keep the bus across its next ack
sel  out  NCH  one-hot grant; sel[i] = channel i owns the bus
seln  out  SELW  encoded owner index; SELW = max(1, clog2(NCH))
gnt_vld  out  1  1 = sel/seln describe an active owner
timeout  out  1  one-cycle pulse when the watchdog forces re-arbitration (0 when feature absent)

Behaviour:
- Reset (synchronous, clk rising edge, rst=1): sel=0, seln=0, gnt_vld=0, timeout=0, RR pointer=NCH-1 (so channel 0 is searched first), state=IDLE, watchdog=0. Reset overrides ce, ack and req on the same edge.
- FSM states: IDLE (no owner), OWNED (owner holds the bus).
- IDLE, ce=1, any req:
  - Pick the winner w and load sel=1<<w, seln=w, gnt_vld=1.
  - Go to OWNED. Outputs are registered, so the grant is visible one clk after the sampling edge.
- IDLE, ce=0 or req=0: hold all outputs. sel/seln keep the last owner, and gnt_vld stays 0.
- OWNED, ce=0 or ack=0: hold all outputs. ack without ce is ignored.
- OWNED, ce=1, ack=1:
  - If lock[seln]=1 and req[seln]=1: same owner retained; outputs unchanged; RR pointer unchanged.
  - Else if any req: re-arbitrate and load the new winner. The current owner may win again if it is the only requester, or under fixed priority.
  - Else: go to IDLE with gnt_vld=0; sel/seln hold the last owner.
- ack in IDLE is ignored.
- Winner selection:
  - RR=1: first set req bit scanning ptr+1, ptr+2, … with wrap modulo NCH. ptr is updated to w on every grant load.
  - RR=0: lowest set index. ptr is unused.
- sel is always one-hot or zero; it is zero only after reset until the first grant. seln always equals the index of the set sel bit.
- req deasserting while OWNED does not revoke the grant; only ack (or the watchdog) ends ownership.
- lock on a non-owner channel has no effect.

Optional Feature:
PSG_ARB_WATCHDOG_EN
- Defined:
  - In OWNED, the counter increments on each ce tick with ack=0 and clears on ce&ack or on leaving OWNED.
  - When the counter reaches TIMEOUT on a ce tick: timeout=1 for one clk, and the block acts as ce&ack with lock ignored. The current owner is excluded from this re-arbitration. If no other req is set, go to IDLE.
  - Counter resets to 0.
- Not defined: no counter; timeout tied 0; ownership lasts until ack indefinitely.

Test Plan:
1. rst=1 with ce=1, ack=1, req=8'hFF -> after edge sel=0, seln=0, gnt_vld=0. First ce with req=8'h81 -> sel=8'h01, seln=0, gnt_vld=1.
2. RR=1, req=8'hFF held, ce=1, ack pulsed each ce -> seln sequence 0,1,2,…,7,0. With RR=0 the same stimulus gives seln stuck at 0.
3. Owner 3, lock[3]=1, req[3]=1, req[5]=1, ce&ack -> seln stays 3. Then drop lock[3], ce&ack -> seln=5, sel=8'h20.
4. Owner 2, ack=1 with ce=0 for 4 clks -> no change. Then ce&ack with req=0 -> gnt_vld=0, sel=8'h04, seln=2 held.
5. NCH=5, owner 4, req=5'b00011, ce&ack -> seln=0 (wrap). NCH=2 build gives SELW=1.
6. With PSG_ARB_WATCHDOG_EN, TIMEOUT=4: owner 1, ack=0, req=8'h06 -> on 4th ce tick timeout pulses one clk and seln=2. With only req[1] set -> gnt_vld=0.
